async_fifo_wr_sched: RTL and testbench
======================================

Name: async_fifo_wr_sched

Overview:
Write-side scheduler for the async FIFO. It shares the single FIFO write port among NREQ packet requesters using round-robin arbitration with per-packet lock. It owns the binary and Gray write pointers and the registered full flag, which are computed against the read pointer already synchronized into wclk (wq2_rptr). The block sits in the wclk domain, between the requesters and the FIFO memory write port.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >= 4; AW = log2(DEPTH)
DWIDTH, 8, data width per beat
NREQ, 4, number of requesters; >= 2
AFULL_THRESH, 12, almost-full level (used only with optional feature); 1..DEPTH-1

Ports:
wclk  in  1  write clock
wrst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester beat valid
req_data  in  NREQ*DWIDTH  per-requester beat; requester i uses bits [i*DWIDTH +: DWIDTH]
req_last  in  NREQ  marks last beat of packet
req_ready  out  NREQ  beat accepted when valid&ready
wq2_rptr  in  AW+1  Gray read pointer, already synchronized into wclk
wen  out  1  memory write enable
waddr  out  AW  memory write address (wbin[AW-1:0])
wdata  out  DWIDTH  memory write data
wptr  out  AW+1  Gray write pointer, registered, goes to the read-side synchronizer
wfull  out  1  FIFO full, registered
wcount  out  AW+1  fill level as seen from wclk, 0..DEPTH

Behaviour:
- Reset values: wbin=0, wptr=0, wfull=0, state=IDLE, owner=none, rr_ptr=0; req_ready=0, wen=0, wcount=0.
- FSM states: IDLE and LOCK.
- IDLE: the owner is the first requester with req_valid set, searching from rr_ptr upward with wrap. The grant is combinational, so the first beat is accepted in the same cycle (zero bubble).
- LOCK: the owner is the registered lock_id. Other requesters are ignored.
- req_ready[i] = (owner==i) & ~wfull. Every other ready bit is 0.
- Accept = req_valid[owner] & req_ready[owner]. On an accept: wen=1, wdata=req_data[owner], waddr=wbin[AW-1:0], all in the same cycle.
- IDLE to LOCK: on accepting a non-last beat; lock_id <= owner.
- LOCK to IDLE: on accepting a beat with req_last=1.
- A single-beat packet (last beat accepted in IDLE) stays in IDLE.
- On every last-beat accept: rr_ptr <= owner+1 mod NREQ.
- In LOCK with req_valid[lock_id]=0: hold the lock, no write, no re-arbitration.
- Pointers: wbin <= wbin + wen; wptr <= bin2gray(wbin + wen). Both wrap mod 2^(AW+1).
- Full: wfull <= (bin2gray(wbin+wen) == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}).
  - wfull asserts in the same edge as the write that fills the FIFO.
  - wfull deasserts one cycle after wq2_rptr advances.
- wcount = wbin - gray2bin(wq2_rptr), combinational from registered values.
- Full while valid: no accept. Lock and rr_ptr are unchanged. Data is held by the requester.
- Reset mid-packet: lock is dropped and the FSM returns to IDLE. The partial packet stays in memory; the requester restarts its packet.
- wq2_rptr is treated as stable within wclk. The block adds no synchronizer.

Optional Feature:
Macro ASYNC_FIFO_WR_AFULL_EN.
- Defined: adds output wafull (1 bit, registered, reset 0).
  - wafull <= (next fill level >= AFULL_THRESH), where next fill level = (wbin+wen) - gray2bin(wq2_rptr).
  - While wafull=1 in IDLE, new packets are not granted; all req_ready are 0. A packet already in LOCK continues until wfull.
- Undefined: no wafull port and no effect on granting.

Decomposition:
- Package async_fifo_pkg:
  - AW derivation helper
  - bin2gray and gray2bin functions
  - fsm state typedef (IDLE, LOCK)
  - these are shared with the read-side empty logic
- One sub-module: async_fifo_rr_arb. Inputs: req vector and rr_ptr. Outputs: one-hot grant and encoded owner; purely combinational.
- Pointer, full, lock and FSM logic stay in the top.

Test Plan:
- Reset, then req_valid=4'b0110, all last=1, wq2_rptr fixed 0 -> grants req1 (cycle 0), then req2 (cycle 1), then req1; wptr Gray sequence 0,1,3,2.
- req0 sends a 3-beat packet while req3 valid -> req0 beats at waddr 0,1,2 uninterrupted; req3 is first granted the cycle after req0's last beat.
- Req0 valid gap mid-packet (valid low 2 cycles) -> lock held, wen=0, req3 stays unready, no re-arbitration.
- Write 16 beats with wq2_rptr=0 -> wfull=1 after the 16th write, wcount=16, wptr=5'b11000, ready=0; drive wq2_rptr=5'b00001 -> wfull=0 next cycle, wcount=15.
- Pointer wrap: 40 writes with wq2_rptr tracking (gray2bin lag 2) -> waddr wraps 15->0, wptr wraps via 5'b10000, wfull never asserts.
- Assert wrst_n=0 mid-packet, release, then req2 valid -> state IDLE, wptr=0, wfull=0, rr_ptr=0 (req0 priority); with ASYNC_FIFO_WR_AFULL_EN, fill=12 -> wafull=1 and no new grant.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: address-width derivation, Gray conversion and the
// write-scheduler FSM encoding. Used by both the write and read pointer logic.
package async_fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } wr_state_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Callers zero-extend to 32 bits and size-cast the result back down.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_rr_arb.sv
// Combinational round-robin arbiter: the first set request at or above rr_ptr,
// with wrap, wins. Produces a one-hot grant and its encoded index.
module async_fifo_rr_arb #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   owner,
    output logic            any
);

    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        owner = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                owner      = idx;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_sched.sv
// Async FIFO write-side scheduler: round-robin packet arbitration with per-packet
// lock, write pointers and registered full. ASYNC_FIFO_WR_AFULL_EN adds wafull.
//   state | meaning
//   IDLE  | no packet in flight; owner chosen by the round-robin arbiter
//   LOCK  | packet in flight; lock_id owns the write port until its last beat
module async_fifo_wr_sched
    import async_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DWIDTH       = 8,
    parameter int NREQ         = 4,
    parameter int AFULL_THRESH = 12,
    localparam int AW          = addr_width(DEPTH)
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    input  logic [AW:0]            wq2_rptr,
    output logic                   wen,
    output logic [AW-1:0]          waddr,
    output logic [DWIDTH-1:0]      wdata,
    output logic [AW:0]            wptr,
    output logic                   wfull,
`ifdef ASYNC_FIFO_WR_AFULL_EN
    output logic                   wafull,
`endif
    output logic [AW:0]            wcount
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = AW + 1;

    wr_state_t       state, state_nxt;
    logic [IW-1:0]   lock_id, rr_ptr, rr_nxt, owner, arb_owner;
    logic [NREQ-1:0] arb_grant, owner_oh;
    logic            arb_any, grant_block, accept, owner_last, full_nxt;
    logic [AW:0]     wbin, wbin_nxt, wgray_nxt, rbin;

    async_fifo_rr_arb #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .owner  (arb_owner),
        .any    (arb_any)
    );

`ifdef ASYNC_FIFO_WR_AFULL_EN
    assign grant_block = wafull;
`else
    assign grant_block = 1'b0;
`endif

    always_comb begin
        owner    = lock_id;
        owner_oh = '0;
        if (state == LOCK) begin
            owner_oh[lock_id] = 1'b1;
        end else if (arb_any && !grant_block) begin
            owner    = arb_owner;
            owner_oh = arb_grant;
        end
    end

    // Ready is also held low while reset is asserted so nothing looks accepted.
    assign req_ready  = (wfull || !wrst_n) ? '0 : owner_oh;
    assign accept     = |(req_valid & req_ready);
    assign owner_last = req_last[owner];

    assign wen   = accept;
    assign waddr = wbin[AW-1:0];
    assign wdata = req_data[int'(owner)*DWIDTH +: DWIDTH];

    assign wbin_nxt  = wbin + PW'(accept);
    assign wgray_nxt = PW'(bin2gray(32'(wbin_nxt)));
    assign rbin      = PW'(gray2bin(32'(wq2_rptr)));
    assign wcount    = wbin - rbin;
    assign full_nxt  = (wgray_nxt == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]});
    assign rr_nxt    = (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !owner_last) state_nxt = LOCK;
            LOCK:    if (accept && owner_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state   <= IDLE;
            lock_id <= '0;
            rr_ptr  <= '0;
            wbin    <= '0;
            wptr    <= '0;
            wfull   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                lock_id <= owner;
            end
            if (accept && owner_last) begin
                rr_ptr <= rr_nxt;
            end
            wbin  <= wbin_nxt;
            wptr  <= wgray_nxt;
            wfull <= full_nxt;
        end
    end

`ifdef ASYNC_FIFO_WR_AFULL_EN
    logic [AW:0] fill_nxt;
    assign fill_nxt = wbin_nxt - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (fill_nxt >= PW'(AFULL_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_sched.sv
// Directed bench for async_fifo_wr_sched (DEPTH=16, DWIDTH=8, NREQ=4).
module tb_async_fifo_wr_sched;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic [4:0]  wq2_rptr, wptr, wcount;
    logic        wen, wfull;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
`ifdef ASYNC_FIFO_WR_AFULL_EN
    logic        wafull;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    async_fifo_wr_sched #(
        .DEPTH(16), .DWIDTH(8), .NREQ(4), .AFULL_THRESH(12)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wq2_rptr  (wq2_rptr),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .wptr      (wptr),
        .wfull     (wfull),
`ifdef ASYNC_FIFO_WR_AFULL_EN
        .wafull    (wafull),
`endif
        .wcount    (wcount)
    );

    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // Requester i carries byte 8'h10*(i+1) + b.
    task automatic set_data(input logic [7:0] b);
        req_data = {8'h40 + b, 8'h30 + b, 8'h20 + b, 8'h10 + b};
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        wq2_rptr  = '0;
        wrst_n    = 1'b0;
        tick();
        tick();
        wrst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] wb, rb;
        req_data = '0;
        do_reset();
        check_eq("rst_wptr", wptr, 0);
        check_eq("rst_wfull", wfull, 0);
        check_eq("rst_wcount", wcount, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_wen", wen, 0);

        // Round-robin among single-beat packets from req1 and req2.
        req_valid = 4'b0110; req_last = 4'hF; set_data(0); #1;
        check_eq("rr0_ready", req_ready, 4'b0010);
        check_eq("rr0_wen", wen, 1);
        check_eq("rr0_waddr", waddr, 0);
        check_eq("rr0_wdata", wdata, 8'h20);
        tick(); check_eq("rr0_wptr", wptr, 5'b00001);
        set_data(1); #1;
        check_eq("rr1_ready", req_ready, 4'b0100);
        check_eq("rr1_waddr", waddr, 1);
        check_eq("rr1_wdata", wdata, 8'h31);
        tick(); check_eq("rr1_wptr", wptr, 5'b00011);
        set_data(2); #1;
        check_eq("rr2_ready", req_ready, 4'b0010);
        check_eq("rr2_wdata", wdata, 8'h22);
        tick(); check_eq("rr2_wptr", wptr, 5'b00010);
        check_eq("rr2_wcount", wcount, 3);
        req_valid = '0;

        // req0 3-beat packet with a 2-cycle valid gap while req3 waits.
        do_reset();
        req_valid = 4'b1001; req_last = 4'b1000; set_data(0); #1;
        check_eq("pk0_ready", req_ready, 4'b0001);
        check_eq("pk0_waddr", waddr, 0);
        check_eq("pk0_wdata", wdata, 8'h10);
        tick();
        set_data(1); #1;
        check_eq("pk1_ready", req_ready, 4'b0001);
        check_eq("pk1_waddr", waddr, 1);
        check_eq("pk1_wdata", wdata, 8'h11);
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("gap_ready", req_ready, 4'b0001);
            check_eq("gap_wen", wen, 0);
            tick();
            check_eq("gap_wptr", wptr, 5'b00011);
        end
        req_valid = 4'b1001; req_last = 4'b1001; set_data(2); #1;
        check_eq("pk2_ready", req_ready, 4'b0001);
        check_eq("pk2_waddr", waddr, 2);
        check_eq("pk2_wdata", wdata, 8'h12);
        tick();
        set_data(3); #1;
        check_eq("r3_ready", req_ready, 4'b1000);
        check_eq("r3_waddr", waddr, 3);
        check_eq("r3_wdata", wdata, 8'h43);
        tick(); check_eq("r3_wptr", wptr, 5'b00110);
        req_valid = '0;

        // Fill to full, then release one entry from the read side.
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            set_data(8'(i)); #1;
            check_eq("fill_waddr", waddr, i);
            check_eq("fill_wen", wen, 1);
            tick();
        end
        check_eq("full_wfull", wfull, 1);
        check_eq("full_wcount", wcount, 16);
        check_eq("full_wptr", wptr, 5'b11000);
        check_eq("full_ready", req_ready, 0);
        check_eq("full_wen", wen, 0);
        tick();
        check_eq("full_hold_wptr", wptr, 5'b11000);
        wq2_rptr = 5'b00001; #1;
        check_eq("rd1_wcount", wcount, 15);
        check_eq("rd1_wfull_before", wfull, 1);
        tick();
        check_eq("rd1_wfull_after", wfull, 0);
        check_eq("rd1_ready", req_ready, 4'b0001);
        tick();
        check_eq("refill_wfull", wfull, 1);
        check_eq("refill_wcount", wcount, 16);
        req_valid = '0;

        // 40 writes with the read pointer trailing by two; pointer wraps.
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0001;
        wb = '0;
        for (int i = 0; i < 40; i++) begin
            rb = (i >= 2) ? wb - 5'd2 : 5'd0;
            wq2_rptr = rb ^ (rb >> 1);
            set_data(8'(i)); #1;
            check_eq("wrap_waddr", waddr, wb[3:0]);
            check_eq("wrap_wen", wen, 1);
            tick();
            wb = wb + 5'd1;
            check_eq("wrap_wptr", wptr, wb ^ (wb >> 1));
            check_eq("wrap_wfull", wfull, 0);
        end
        req_valid = '0;

        // Reset while req2 holds a lock after req1 has moved rr_ptr.
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0010; set_data(0); #1;
        check_eq("mr_r1_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0100; req_last = 4'b0000; #1;
        check_eq("mr_r2_ready", req_ready, 4'b0100);
        tick();
        #2 wrst_n = 1'b0; #1;
        check_eq("mr_wptr", wptr, 0);
        check_eq("mr_wfull", wfull, 0);
        check_eq("mr_wcount", wcount, 0);
        check_eq("mr_ready", req_ready, 0);
        tick();
        wrst_n = 1'b1;
        req_valid = 4'b0101; req_last = 4'b0101; set_data(5); #1;
        check_eq("mr_after_ready", req_ready, 4'b0001);
        check_eq("mr_after_waddr", waddr, 0);
        check_eq("mr_after_wdata", wdata, 8'h15);
        tick();
        req_valid = '0;

`ifdef ASYNC_FIFO_WR_AFULL_EN
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i == 11) check_eq("af_pre_wafull", wafull, 0);
            tick();
        end
        check_eq("af_wafull", wafull, 1);
        check_eq("af_wcount", wcount, 12);
        check_eq("af_ready", req_ready, 0);
        check_eq("af_wen", wen, 0);
        req_valid = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
